// File: rtl/priority_enc_n_seq_v.sv
// Registered N-bit priority serialiser: loads a request vector and emits the index of each set bit, one per handshake.
// Build option: define PRIO_ENC_LSB_FIRST_EN to emit the lowest index first instead of the highest.
module priority_enc_n_seq_v #(
    parameter int N     = 8,
    parameter int OUT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_code,
    input  logic             i_load,
    output logic             o_ready,
    output logic [OUT_W-1:0] o_code,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic             o_empty
);

    // state  | meaning
    // IDLE   | no pending bits, o_ready=1, accepts i_load
    // SCAN   | presenting pending bits one per transfer
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]       r_state;
    logic [N-1:0]     r_pending;
    logic [OUT_W-1:0] r_code;
    logic             r_valid;
    logic             r_last;
    logic             r_empty;
    logic             r_ready;
    logic [N-1:0]     w_remain;

    function automatic logic [OUT_W-1:0] f_pick(input logic [N-1:0] v);
        logic [OUT_W-1:0] idx;
        idx = '0;
`ifdef PRIO_ENC_LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = OUT_W'(i);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = OUT_W'(i);
        end
`endif
        return idx;
    endfunction

    function automatic logic f_single(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // Pending vector with the currently presented bit removed
    always_comb begin
        w_remain         = r_pending;
        w_remain[r_code] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_empty   <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_empty <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_load) begin
                        if (i_code == '0) begin
                            r_empty <= 1'b1;
                        end else begin
                            r_pending <= i_code;
                            r_code    <= f_pick(i_code);
                            r_last    <= f_single(i_code);
                            r_valid   <= 1'b1;
                            r_ready   <= 1'b0;
                            r_state   <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_valid && i_ready) begin
                        if (r_last) begin
                            r_pending <= '0;
                            r_valid   <= 1'b0;
                            r_last    <= 1'b0;
                            r_ready   <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_pending <= w_remain;
                            r_code    <= f_pick(w_remain);
                            r_last    <= f_single(w_remain);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_code  = r_code;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_empty = r_empty;

endmodule

// File: tb/tb_priority_enc_n_seq_v.sv
// Directed bench for priority_enc_n_seq_v (N=8): vector table plus hand-written hold/ignore/reset sequences.
module tb_priority_enc_n_seq_v;

    logic       clk;
    logic       rst_n;
    logic [7:0] code_in;
    logic       load;
    logic       rdy_out;
    logic [2:0] code_out;
    logic       valid;
    logic       dn_ready;
    logic       last;
    logic       empty;

    int total = 0;
    int bad   = 0;

    priority_enc_n_seq_v #(.N(8), .OUT_W(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_code  (code_in),
        .i_load  (load),
        .o_ready (rdy_out),
        .o_code  (code_out),
        .o_valid (valid),
        .i_ready (dn_ready),
        .o_last  (last),
        .o_empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Codes listed highest index first; the LSB-first build walks them in reverse.
    typedef struct {
        logic [7:0]      vec;
        int              n;
        logic [7:0][2:0] exp;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ord(input vec_t v, input int k);
`ifdef PRIO_ENC_LSB_FIRST_EN
        return v.exp[v.n - 1 - k];
`else
        return v.exp[k];
`endif
    endfunction

    initial begin
        logic [2:0] c_first, c_second;

        tbl[0].vec = 8'b1010_0100; tbl[0].n = 3; tbl[0].exp = '0;
        tbl[0].exp[0] = 3'd7; tbl[0].exp[1] = 3'd5; tbl[0].exp[2] = 3'd2;
        tbl[1].vec = 8'h80; tbl[1].n = 1; tbl[1].exp = '0; tbl[1].exp[0] = 3'd7;
        tbl[2].vec = 8'h00; tbl[2].n = 0; tbl[2].exp = '0;
        tbl[3].vec = 8'hFF; tbl[3].n = 8; tbl[3].exp = '0;
        for (int i = 0; i < 8; i++) tbl[3].exp[i] = 3'(7 - i);
        tbl[4].vec = 8'h01; tbl[4].n = 1; tbl[4].exp = '0; tbl[4].exp[0] = 3'd0;

        // Reset with load asserted
        rst_n = 1'b0; load = 1'b1; code_in = 8'hFF; dn_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_valid", valid, 0);
            chk("rst_code", code_out, 0);
            chk("rst_ready", rdy_out, 1);
            chk("rst_empty", empty, 0);
            chk("rst_last", last, 0);
        end
        rst_n = 1'b1; load = 1'b0; code_in = 8'h00;
        step();
        chk("idle_valid", valid, 0);

        // Table: load, drain with i_ready=1, confirm return to idle
        for (int t = 0; t < 5; t++) begin
            load = 1'b1; code_in = tbl[t].vec;
            step();
            load = 1'b0;
            if (tbl[t].n == 0) begin
                chk("empty_pulse", empty, 1);
                chk("empty_valid", valid, 0);
                chk("empty_ready", rdy_out, 1);
                step();
                chk("empty_clear", empty, 0);
            end else begin
                for (int k = 0; k < tbl[t].n; k++) begin
                    chk("tbl_valid", valid, 1);
                    chk("tbl_code", code_out, ord(tbl[t], k));
                    chk("tbl_last", last, (k == tbl[t].n - 1) ? 1 : 0);
                    chk("tbl_ready", rdy_out, 0);
                    step();
                end
                chk("tbl_end_valid", valid, 0);
                chk("tbl_end_last", last, 0);
                chk("tbl_end_ready", rdy_out, 1);
                chk("tbl_code_held", code_out, ord(tbl[t], tbl[t].n - 1));
            end
        end

        // Back-pressure hold on 8'h81
`ifdef PRIO_ENC_LSB_FIRST_EN
        c_first = 3'd0; c_second = 3'd7;
`else
        c_first = 3'd7; c_second = 3'd0;
`endif
        dn_ready = 1'b0; load = 1'b1; code_in = 8'h81;
        step();
        load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("hold_valid", valid, 1);
            chk("hold_code", code_out, c_first);
            chk("hold_last", last, 0);
            step();
        end
        chk("hold_code4", code_out, c_first);
        dn_ready = 1'b1;
        step();
        chk("hold_code2", code_out, c_second);
        chk("hold_last2", last, 1);
        step();
        chk("hold_done", valid, 0);

        // Loads during SCAN and on the final transfer are ignored
`ifdef PRIO_ENC_LSB_FIRST_EN
        c_first = 3'd0; c_second = 3'd1;
`else
        c_first = 3'd1; c_second = 3'd0;
`endif
        load = 1'b1; code_in = 8'h03;
        step();
        code_in = 8'h80;
        chk("ign_code1", code_out, c_first);
        chk("ign_last1", last, 0);
        step();
        chk("ign_code2", code_out, c_second);
        chk("ign_last2", last, 1);
        step();
        load = 1'b0;
        chk("ign_valid", valid, 0);
        chk("ign_ready", rdy_out, 1);
        chk("ign_empty", empty, 0);
        step();
        chk("ign_still_idle", valid, 0);

        // Reset mid-SCAN
        load = 1'b1; code_in = 8'hFF;
        step();
        load = 1'b0;
`ifdef PRIO_ENC_LSB_FIRST_EN
        chk("mid_first", code_out, 0);
`else
        chk("mid_first", code_out, 7);
`endif
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_code", code_out, 0);
        chk("mid_rst_ready", rdy_out, 1);
        rst_n = 1'b1;
        step();
        chk("mid_after_valid", valid, 0);
        step();
        chk("mid_after_valid2", valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
